// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetch/decode stage of the 8-bit single-cycle processor.
// Holds a writable program memory and the PC, runs an IDLE/RUN/HALT state
// machine, and splits each 12-bit instruction into register-file control
// fields. Jumps and zero-flag branches are resolved here.
//
// Optional feature: define IFD_INSTR_COUNT_EN to build the saturating
// retired-instruction counter; otherwise Instr_Count is tied to zero.
module instr_fetch_decode #(
    parameter int PROG_DEPTH = 64,
    parameter int PC_W       = 6
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Prog_We,
    input  logic [PC_W-1:0] Prog_Addr,
    input  logic [11:0]     Prog_Data,
    input  logic            Zero_In,
    output logic [PC_W-1:0] PC,
    output logic [2:0]      Read_Reg_Num,
    output logic [2:0]      Write_Reg_Num,
    output logic [5:0]      Immediate_Raw,
    output logic            RegWrite,
    output logic            ImmSel,
    output logic [2:0]      Alu_Op,
    output logic            Running,
    output logic            Halted,
    output logic [15:0]     Instr_Count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b100;
    localparam logic [2:0] OP_BEQZ = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Sign-extend a 6-bit jump offset to PC width (PC arithmetic wraps).
    function automatic logic [PC_W-1:0] sext6(input logic [5:0] v);
        logic [PC_W-1:0] r;
        for (int i = 0; i < PC_W; i++) begin
            r[i] = v[(i < 6) ? i : 5];
        end
        return r;
    endfunction

    // Sign-extend a 3-bit branch offset to PC width.
    function automatic logic [PC_W-1:0] sext3(input logic [2:0] v);
        logic [PC_W-1:0] r;
        for (int i = 0; i < PC_W; i++) begin
            r[i] = v[(i < 3) ? i : 2];
        end
        return r;
    endfunction

    logic [11:0]     mem [PROG_DEPTH];
    logic [11:0]     instr;
    logic [2:0]      opcode;
    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic            run;

    assign instr         = mem[pc];
    assign opcode        = instr[11:9];
    assign run           = (state == S_RUN);
    assign PC            = pc;
    assign Write_Reg_Num = instr[8:6];
    assign Read_Reg_Num  = instr[5:3];
    assign Immediate_Raw = instr[5:0];

    // Program memory write port; loading is only allowed while not running,
    // and contents deliberately survive Reset.
    always_ff @(posedge Clk) begin
        if (Prog_We && !run) begin
            mem[Prog_Addr] <= Prog_Data;
        end
    end

    // State and PC registers, asynchronously returned to IDLE at PC 0.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Next-state / next-PC resolution and decoded control outputs.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        RegWrite   = 1'b0;
        Alu_Op     = OP_NOP;
        ImmSel     = (opcode == OP_JMP);
        Running    = run;
        Halted     = (state == S_HALT);
        case (state)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    state_next = S_RUN;
                    pc_next    = '0;
                end
            end
            S_RUN: begin
                Alu_Op   = opcode;
                RegWrite = (opcode != OP_NOP) && (opcode <= OP_MOV);
                case (opcode)
                    OP_HALT: state_next = S_HALT;
                    OP_JMP:  pc_next    = pc + sext6(instr[5:0]);
                    OP_BEQZ: pc_next    = Zero_In ? (pc + sext3(instr[2:0]))
                                                  : (pc + PC_W'(1));
                    default: pc_next    = pc + PC_W'(1);
                endcase
            end
            default: begin
                state_next = S_IDLE;
                pc_next    = '0;
            end
        endcase
    end

`ifdef IFD_INSTR_COUNT_EN
    logic [15:0] instr_count;

    // Saturating count of cycles spent in RUN; restarts on each Start.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            instr_count <= 16'h0000;
        end else if (!run && Start) begin
            instr_count <= 16'h0000;
        end else if (run && (instr_count != 16'hFFFF)) begin
            instr_count <= instr_count + 16'd1;
        end
    end

    assign Instr_Count = instr_count;
`else
    assign Instr_Count = 16'h0000;
`endif

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Instruction fetch and decode stage of the 8-bit single-cycle processor, sitting directly upstream of the register file. It holds a small writable program memory and the program counter, and runs a run/halt state machine. It splits each 12-bit instruction into the register-file control fields: read/write register numbers, raw immediate, RegWrite and ImmSel. It also emits an ALU opcode and resolves jumps and zero-flag branches.

## Interface
- PROG_DEPTH, 64, program memory depth in instructions; power of two, 8..256.
- PC_W, 6, PC width; must equal log2(PROG_DEPTH).

- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high.
- Start  in  1  leave IDLE/HALT and run from PC=0.
- Prog_We  in  1  program memory write strobe.
- Prog_Addr  in  PC_W  program memory write address.
- Prog_Data  in  12  instruction to write.
- Zero_In  in  1  registered zero flag from the ALU stage; used by BEQZ.
- PC  out  PC_W  current program counter.
- Read_Reg_Num  out  3  instr[5:3] (rs).
- Write_Reg_Num  out  3  instr[8:6] (rd).
- Immediate_Raw  out  6  instr[5:0].
- RegWrite  out  1  register write enable.
- ImmSel  out  1  1 = 6-bit immediate (jump), 0 = 3-bit immediate.
- Alu_Op  out  3  opcode instr[11:9] while RUN, else 000.
- Running  out  1  state == RUN.
- Halted  out  1  state == HALT.
- Instr_Count  out  16  retired instruction counter (see Configuration).

## Operation
- Instruction format: [11:9] opcode, [8:6] rd, [5:3] rs, [2:0] imm3; JMP uses [5:0] imm6.
- Opcodes:
  - 000 NOP
  - 001 ADD
  - 010 SUB
  - 011 ADDI
  - 100 MOV
  - 101 BEQZ
  - 110 JMP
  - 111 HALT
- RegWrite = 1 only in RUN for opcodes 001–100. ImmSel = 1 only for JMP.
- Field outputs are combinational from the current instruction, Mem[PC]. They are valid in every state; only RegWrite and Alu_Op are gated.
- FSM states:
  - IDLE: Start → RUN with PC=0.
  - RUN: HALT instruction → HALT; otherwise stay.
  - HALT: Start → RUN with PC=0.
  - Start is ignored while in RUN.
- Next PC in RUN:
  - JMP: PC + sext(imm6).
  - BEQZ with Zero_In=1: PC + sext(imm3).
  - HALT: PC unchanged.
  - All others, including BEQZ with Zero_In=0: PC + 1.
- All PC arithmetic is modulo 2^PC_W (wrap-around). A JMP with offset 0 is a legal self-loop.
- Program memory:
  - Write happens on the Clk edge when Prog_We=1, only in IDLE or HALT.
  - Prog_We in RUN is ignored.
  - Memory is not cleared by Reset.

## Timing
- Reset values: state IDLE, PC=0, RegWrite=0, Alu_Op=0, Running=0, Halted=0, Instr_Count=0.
- Reset asserted mid-RUN: immediate return to IDLE and PC=0. RegWrite drops asynchronously.
- Start sampled at the edge: Running=1 on the following cycle, with PC=0 and decode of Mem[0] visible that cycle.
- One instruction per cycle. PC updates at the edge that ends the instruction's cycle.
- HALT instruction: the cycle it is decoded has RegWrite=0. Halted=1 from the next cycle. PC stays at the HALT address.
- Start and Prog_We in the same IDLE cycle: the write occurs and RUN begins next cycle. A write to address 0 is therefore fetched.
- Zero_In is sampled in the same cycle as the BEQZ instruction.

## Configuration
- IFD_INSTR_COUNT_EN defined: Instr_Count increments by 1 at each edge in RUN, including the HALT instruction's cycle. It saturates at 16'hFFFF, is cleared by Reset, and is cleared on Start.
- Not defined: Instr_Count is tied to 16'h0000 and no counter logic is generated.

## Test plan
- Reset, then check outputs → PC=0, Running=0, Halted=0, RegWrite=0, Instr_Count=0.
- Load Mem[0]=12'h24A (ADD rd=1, rs=1, imm3=2), Mem[1]=12'hE00 (HALT); pulse Start → cycle 1: PC=0, Write_Reg_Num=1, Read_Reg_Num=1, RegWrite=1, Alu_Op=001. Cycle 2: PC=1, RegWrite=0. Cycle 3: Halted=1, PC=1, Instr_Count=2 (macro on).
- JMP at PC=2 with imm6=6'h3E (−2) → next PC=0, ImmSel=1, Immediate_Raw=6'h3E. JMP at PC=0 with imm6=6'h3F → next PC=63 (wrap).
- BEQZ at PC=4 with imm3=3'b011: Zero_In=1 → next PC=7; Zero_In=0 → next PC=5.
- Prog_We=1 during RUN to the executing address → memory unchanged. Start during RUN → no PC reset.
- Assert Reset mid-RUN at PC=5 → PC=0, IDLE, RegWrite=0 immediately. Program contents preserved across a subsequent Start.
